// File: rtl/loopback_rx_pkt_size_monitor.sv
// rtl/loopback_rx_pkt_size_monitor.sv - rx packet size monitor feeding a 32-bit software status register
module loopback_rx_pkt_size_monitor #(
    parameter int MIN_PKT_WORDS = 2,
    parameter int MAX_PKT_WORDS = 1024,
    parameter int LEN_WIDTH     = 12
) (
    input  logic        user_clk,
    input  logic        user_rst,
    input  logic        rx_valid,
    input  logic [63:0] rx_data,
    input  logic        rx_eof,
    input  logic        cnt_clr,
    output logic [31:0] status_word,
    output logic        pkt_strobe
);

    localparam logic [LEN_WIDTH-1:0] LEN_SAT = '1;
    localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(MIN_PKT_WORDS);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_PKT_WORDS);
    localparam logic [13:0]          SMALL_SAT = '1;

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] run_len;
    logic                 pkt_done;
    logic                 overlong_hit;
    logic                 too_small;

    logic                 cnt_clr_q;
    logic                 clr_edge;

    logic                 small_flag_q;
    logic                 over_flag_q;
    logic [13:0]          small_cnt_q;
    logic [3:0]           pkt_cnt_q;
    logic [LEN_WIDTH-1:0] last_len_q;

    // Payload is only observed; folding it keeps the port referenced.
    logic rx_data_unused;
    assign rx_data_unused = ^rx_data;

    assign clr_edge  = cnt_clr & ~cnt_clr_q;
    assign too_small = (run_len < MIN_LEN);

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // run_len is the packet length including the word on the bus this cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pkt_done     = 1'b0;
        overlong_hit = 1'b0;
        if (state_q == IDLE) begin
            run_len = LEN_WIDTH'(1);
        end else if (cnt_q == LEN_SAT) begin
            run_len = LEN_SAT;
        end else begin
            run_len = cnt_q + LEN_WIDTH'(1);
        end
        if (rx_valid) begin
            overlong_hit = (run_len > MAX_LEN);
            if (rx_eof) begin
                pkt_done = 1'b1;
                state_d  = IDLE;
                cnt_d    = '0;
            end else begin
                state_d  = IN_PKT;
                cnt_d    = run_len;
            end
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            cnt_clr_q    <= 1'b0;
            pkt_strobe   <= 1'b0;
            small_flag_q <= 1'b0;
            over_flag_q  <= 1'b0;
            small_cnt_q  <= '0;
            pkt_cnt_q    <= '0;
            last_len_q   <= '0;
        end else begin
            cnt_clr_q  <= cnt_clr;
            pkt_strobe <= pkt_done & ~clr_edge;
            // A clear edge discards any same-cycle packet update.
            if (clr_edge) begin
                small_flag_q <= 1'b0;
                over_flag_q  <= 1'b0;
                small_cnt_q  <= '0;
                pkt_cnt_q    <= '0;
                last_len_q   <= '0;
            end else begin
                if (overlong_hit) begin
                    over_flag_q <= 1'b1;
                end
                if (pkt_done) begin
                    last_len_q <= run_len;
                    pkt_cnt_q  <= pkt_cnt_q + 4'd1;
                    if (too_small) begin
                        small_flag_q <= 1'b1;
                        if (small_cnt_q != SMALL_SAT) begin
                            small_cnt_q <= small_cnt_q + 14'd1;
                        end
                    end
                end
            end
        end
    end

    assign status_word = {small_flag_q, over_flag_q, small_cnt_q, pkt_cnt_q, last_len_q};

endmodule

// File: tb/tb_loopback_rx_pkt_size_monitor.sv
// tb/tb_loopback_rx_pkt_size_monitor.sv - directed self-checking bench for loopback_rx_pkt_size_monitor
module tb_loopback_rx_pkt_size_monitor;

    logic        user_clk = 1'b0;
    logic        user_rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [63:0] rx_data  = '0;
    logic        rx_eof   = 1'b0;
    logic        cnt_clr  = 1'b0;
    logic [31:0] status_word;
    logic        pkt_strobe;

    int checks   = 0;
    int failures = 0;

    loopback_rx_pkt_size_monitor #(
        .MIN_PKT_WORDS(2),
        .MAX_PKT_WORDS(1024),
        .LEN_WIDTH(12)
    ) dut (
        .user_clk   (user_clk),
        .user_rst   (user_rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_eof     (rx_eof),
        .cnt_clr    (cnt_clr),
        .status_word(status_word),
        .pkt_strobe (pkt_strobe)
    );

    always #5 user_clk = ~user_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        user_rst = 1'b1;
        #3;
        check("rst_status", status_word, 32'h0);
        check("rst_strobe", {31'b0, pkt_strobe}, 32'h0);
        @(posedge user_clk);
        #1;
        user_rst = 1'b0;
    endtask

    // One accepted word; returns 1 time unit after the edge that took it.
    task automatic send_word(input logic eof);
        rx_valid = 1'b1;
        rx_eof   = eof;
        rx_data  = {$urandom, $urandom};
        @(posedge user_clk);
        #1;
        rx_valid = 1'b0;
        rx_eof   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge user_clk);
            #1;
        end
    endtask

    initial begin
        // Single-word packet is too small
        do_reset();
        idle(2);
        send_word(1'b1);
        check("one_word_status", status_word, 32'h8001_1001);
        check("one_word_strobe", {31'b0, pkt_strobe}, 32'h1);
        idle(1);
        check("one_word_strobe_drop", {31'b0, pkt_strobe}, 32'h0);
        check("one_word_hold", status_word, 32'h8001_1001);

        // 2-word and 8-word packets with rx_valid gaps
        do_reset();
        send_word(1'b0);
        idle(3);
        check("gap_no_strobe", {31'b0, pkt_strobe}, 32'h0);
        send_word(1'b1);
        check("two_word_status", status_word, 32'h0000_1002);
        check("two_word_strobe", {31'b0, pkt_strobe}, 32'h1);
        for (int i = 0; i < 7; i++) begin
            send_word(1'b0);
            if (i % 2 == 0) idle(1);
        end
        check("eight_mid_status", status_word, 32'h0000_1002);
        send_word(1'b1);
        check("eight_word_status", status_word, 32'h0000_2008);

        // 1100-word packet: overlong flag sets mid-packet
        do_reset();
        for (int i = 1; i <= 1024; i++) send_word(1'b0);
        check("long_at_1024", status_word, 32'h0000_0000);
        send_word(1'b0);
        check("long_at_1025", status_word, 32'h4000_0000);
        for (int i = 1026; i < 1100; i++) send_word(1'b0);
        check("long_pre_eof", status_word, 32'h4000_0000);
        send_word(1'b1);
        check("long_eof_status", status_word, 32'h4000_144C);
        check("long_eof_strobe", {31'b0, pkt_strobe}, 32'h1);

        // 16385 single-word packets: too-small counter saturates
        do_reset();
        for (int i = 1; i <= 16385; i++) begin
            send_word(1'b1);
            if (i == 16383) check("sat_16383", status_word, 32'hBFFF_F001);
            if (i == 16384) check("sat_16384", status_word, 32'hBFFF_0001);
        end
        check("sat_16385", status_word, 32'hBFFF_1001);

        // Clear edge coincident with eof wins; held-high clears once
        do_reset();
        send_word(1'b1);
        check("clr_pre", status_word, 32'h8001_1001);
        send_word(1'b0);
        send_word(1'b0);
        cnt_clr = 1'b1;
        send_word(1'b1);
        check("clr_status", status_word, 32'h0);
        check("clr_strobe", {31'b0, pkt_strobe}, 32'h0);
        send_word(1'b0);
        send_word(1'b0);
        send_word(1'b1);
        check("clr_held_status", status_word, 32'h0000_1003);
        check("clr_held_strobe", {31'b0, pkt_strobe}, 32'h1);
        cnt_clr = 1'b0;
        idle(2);

        // Clear mid-packet leaves the in-flight packet intact
        send_word(1'b0);
        cnt_clr = 1'b1;
        send_word(1'b0);
        check("clr_mid_status", status_word, 32'h0);
        cnt_clr = 1'b0;
        send_word(1'b1);
        check("clr_mid_eof", status_word, 32'h0000_1003);

        // Async reset mid-packet
        do_reset();
        send_word(1'b1);
        check("arst_pre", status_word, 32'h8001_1001);
        send_word(1'b0);
        send_word(1'b0);
        send_word(1'b0);
        #2;
        user_rst = 1'b1;
        #1;
        check("arst_async_status", status_word, 32'h0);
        check("arst_async_strobe", {31'b0, pkt_strobe}, 32'h0);
        idle(2);
        user_rst = 1'b0;
        idle(1);
        send_word(1'b0);
        send_word(1'b1);
        check("arst_after_status", status_word, 32'h0000_1002);
        check("arst_after_strobe", {31'b0, pkt_strobe}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/loopback_rx_pkt_size_monitor.md
Name: loopback_rx_pkt_size_monitor

Overview:
Monitors the 10GbE loopback receive stream as it enters the rx packet FIFO. Counts packets, flags packets shorter than a programmable minimum ("too small") and longer than a programmable maximum, and records the last packet length. Packs the results into a registered 32-bit status word that directly drives user_data_in of the downstream simulink2ppc software register (Santa_2small), which is clocked on user_clk.

Parameters:
MIN_PKT_WORDS, 2, packets with fewer 64-bit words than this are too small (legal range 1..4095)
MAX_PKT_WORDS, 1024, packets with more words than this are overlong (legal range MIN_PKT_WORDS..4094)
LEN_WIDTH, 12, width of the packet word counter and the last-length field (fixed at 12 for this status layout)

Ports:
user_clk  in  1  sole clock; same clock as the downstream register's user_clk
user_rst  in  1  asynchronous active-high reset
rx_valid  in  1  rx word valid this cycle
rx_data  in  64  rx word (observed only, not stored)
rx_eof  in  1  last word of packet; qualified by rx_valid
cnt_clr  in  1  software clear level; a rising edge clears counts and flags
status_word  out  32  to user_data_in of the software register
pkt_strobe  out  1  one-cycle pulse when status_word updates for a completed packet

Behaviour:
- Reset (async, active-high): state IDLE, word counter 0, status_word 32'h0, pkt_strobe 0, cnt_clr edge register 0.
- status_word layout:
  - [31] sticky too-small flag
  - [30] sticky overlong flag
  - [29:16] too-small packet count, 14-bit, saturates at 16383
  - [15:12] total packet count modulo 16, wraps as a heartbeat
  - [11:0] last packet length in words, saturates at 4095
- FSM IDLE/IN_PKT:
  - IDLE, rx_valid & !rx_eof -> IN_PKT, counter=1.
  - IDLE, rx_valid & rx_eof -> single-word packet, length 1, stays IDLE.
  - IN_PKT, rx_valid & !rx_eof -> counter+1, saturating at 4095.
  - IN_PKT, rx_valid & rx_eof -> length = counter+1 (saturating), -> IDLE, counter=0.
  - rx_valid=0 holds all state.
- Packet completion (eof word accepted at cycle N): at N+1, status_word[11:0]=length, [15:12]+=1, pkt_strobe=1 for exactly one cycle.
  - If length < MIN_PKT_WORDS: [29:16] increments (saturating) and [31] sets, both at N+1.
- Overlong: [30] sets the cycle after the accepted word that makes the running count exceed MAX_PKT_WORDS, i.e. mid-packet without waiting for eof. The packet still completes normally at eof.
- Clear: cnt_clr is registered once and its rising edge is detected.
  - When the edge is detected at cycle C, status_word becomes 32'h0 at C+1.
  - FSM and word counter are not touched, so an in-flight packet still completes and is reported.
  - If a packet completion coincides with the clear cycle, clear wins: that packet's update is discarded and pkt_strobe stays 0.
  - A held-high cnt_clr clears once only.
- Latency: status_word and pkt_strobe are registered, one cycle after the eof word or the clear edge. There is no back-pressure; the block never stalls rx.
- Reset mid-packet: everything returns to reset values. Subsequent words without a new start are counted as a new packet from IDLE.
- Downstream register samples status_word on user_clk; no CDC is done in this block.

Test Plan:
- Reset, then one packet of 1 word (rx_valid&rx_eof) -> next cycle status_word=32'hC001_1001? no: [31]=1,[29:16]=1,[15:12]=1,[11:0]=1 -> 32'h8001_1001, pkt_strobe one cycle.
- Reset, then one 2-word packet followed by one 8-word packet with gaps in rx_valid -> after first 32'h0000_1002, after second 32'h0000_2008; no flags set.
- Reset, then 1100-word packet -> [30] sets the cycle after word 1025 while [11:0] is still 0; at eof status_word=32'h4000_144C.
- Reset, then 16385 single-word packets -> [29:16]=16383 (saturated), [15:12]=1 (16385 mod 16), [31]=1.
- After one 1-word packet, raise cnt_clr in the same cycle as the eof of a 3-word packet and hold it high -> status_word=32'h0 next cycle, pkt_strobe stays 0, no further clear while high; the next 3-word packet gives 32'h0000_1003.
- Assert user_rst asynchronously mid-way through a 5-word packet, then release and send the remaining 2 words ending in eof -> outputs 0 during reset; after the eof, status_word=32'h0000_1002.
